// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants for the instruction-fetch stage: state
//               encodings and default address/data widths used by PC and ROM.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int FETCH_ADDR_W = 15;
    localparam int FETCH_DATA_W = 16;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH_IDLE  = 2'd0;
    localparam fetch_state_t FETCH_REQ   = 2'd1;
    localparam fetch_state_t FETCH_DRAIN = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous prefetch FIFO of {data, addr} entries with push,
//               pop, flush (flush beats push) and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 31,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != CNT_W'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage: single-outstanding ROM requests,
//               prefetch FIFO, valid/ready delivery, redirect flush.
//               Optional macro FETCH_BYPASS_EN: zero-latency ack-to-valid
//               when the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int ENTRY_W = DATA_W + ADDR_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_fetch_ptr;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [ADDR_W-1:0] r_target;
    logic [ADDR_W-1:0] w_ptr_next;
    logic [ADDR_W-1:0] w_addr_next;
    logic [ADDR_W-1:0] w_target_next;

    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_count_after_pop;
    logic [CNT_W-1:0]   w_count_after_push;
    logic               w_empty;
    logic               w_push;
    logic               w_fifo_pop;
    logic               w_flush;
    logic               w_skip_push;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data ({rom_data, r_rom_addr}),
        .pop       (w_fifo_pop),
        .flush     (w_flush),
        .head      (w_head),
        .count     (w_count),
        .empty     (w_empty)
    );

`ifdef FETCH_BYPASS_EN
    logic w_bypass;

    // An ack landing on an empty FIFO is shown to the CPU in the same cycle.
    assign w_bypass    = w_empty && rom_ack && (r_state == FETCH_REQ) && !redirect;
    assign instr_valid = !w_empty || w_bypass;
    assign instr       = w_bypass ? rom_data   : w_head[ENTRY_W-1:ADDR_W];
    assign instr_pc    = w_bypass ? r_rom_addr : w_head[ADDR_W-1:0];
    assign w_skip_push = w_bypass && instr_ready;
`else
    assign instr_valid = !w_empty;
    assign instr       = w_head[ENTRY_W-1:ADDR_W];
    assign instr_pc    = w_head[ADDR_W-1:0];
    assign w_skip_push = 1'b0;
`endif

    assign w_fifo_pop         = instr_valid && instr_ready && !w_empty;
    assign w_count_after_pop  = w_count - CNT_W'(w_fifo_pop);
    assign w_count_after_push = w_count_after_pop + CNT_W'(w_push);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FETCH_IDLE;
            r_fetch_ptr <= '0;
            r_rom_addr  <= '0;
            r_target    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_fetch_ptr <= w_ptr_next;
            r_rom_addr  <= w_addr_next;
            r_target    <= w_target_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_ptr_next    = r_fetch_ptr;
        w_addr_next   = r_rom_addr;
        w_target_next = r_target;
        case (r_state)
            FETCH_IDLE: begin
                if (redirect) begin
                    w_state_next = FETCH_REQ;
                    w_ptr_next   = redirect_addr;
                    w_addr_next  = redirect_addr;
                end else if (w_count_after_pop < CNT_W'(DEPTH)) begin
                    w_state_next = FETCH_REQ;
                    w_addr_next  = r_fetch_ptr;
                end
            end
            FETCH_REQ: begin
                if (redirect && rom_ack) begin
                    w_ptr_next  = redirect_addr;
                    w_addr_next = redirect_addr;
                end else if (redirect) begin
                    // Old request must still complete; its data is dropped.
                    w_state_next  = FETCH_DRAIN;
                    w_target_next = redirect_addr;
                    w_ptr_next    = redirect_addr;
                end else if (rom_ack) begin
                    w_ptr_next = r_rom_addr + ADDR_W'(1);
                    if (w_count_after_push < CNT_W'(DEPTH)) begin
                        w_addr_next = r_rom_addr + ADDR_W'(1);
                    end else begin
                        w_state_next = FETCH_IDLE;
                    end
                end
            end
            FETCH_DRAIN: begin
                if (redirect) begin
                    w_target_next = redirect_addr;
                    w_ptr_next    = redirect_addr;
                end
                if (rom_ack) begin
                    w_state_next = FETCH_REQ;
                    w_addr_next  = redirect ? redirect_addr : r_target;
                    w_ptr_next   = redirect ? redirect_addr : r_target;
                end
            end
            default: begin
                w_state_next = FETCH_IDLE;
            end
        endcase
    end

    always_comb begin
        rom_req = (r_state != FETCH_IDLE);
        w_flush = redirect;
        w_push  = (r_state == FETCH_REQ) && rom_ack && !redirect && !w_skip_push;
    end

    assign rom_addr = r_rom_addr;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly downstream of the program counter and upstream of the CPU decode/execute logic. It keeps its own fetch pointer and issues single-outstanding read requests to a variable-latency instruction ROM over a req/ack handshake. It buffers returned words in a small prefetch FIFO and hands them to the CPU with a valid/ready handshake. A jump (redirect) from the CPU flushes buffered and in-flight instructions and restarts fetch at the target.

Parameters:
ADDR_W, 15, ROM word-address width; the fetch pointer wraps modulo 2^ADDR_W.
DATA_W, 16, instruction width.
DEPTH, 2, prefetch FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  sole clock, rising edge
reset  input  1  synchronous, active-high reset
redirect  input  1  jump taken; restart fetch at redirect_addr
redirect_addr  input  ADDR_W  jump target
rom_req  output  1  ROM read request
rom_addr  output  ADDR_W  ROM read address; stable while rom_req=1
rom_ack  input  1  ROM data valid; meaningful only while rom_req=1
rom_data  input  DATA_W  ROM read data, sampled when rom_ack=1
instr_valid  output  1  instr/instr_pc hold a valid instruction
instr_ready  input  1  CPU accepts the instruction this cycle
instr  output  DATA_W  instruction word
instr_pc  output  ADDR_W  address of instr

Behaviour:
- Reset: fetch_ptr=0, FIFO empty, state=IDLE, rom_req=0, rom_addr=0, instr_valid=0, instr=0, instr_pc=0. Reset wins over every other input in the same cycle.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding.
  - DRAIN: stale request outstanding after a redirect; its response is discarded.
- IDLE->REQ: when no redirect is present and fifo_count < DEPTH (count taken after this cycle's pop). Drive rom_req=1 and rom_addr=fetch_ptr from the next edge. The first request therefore appears in the cycle after reset deasserts, with addr 0.
- REQ: hold rom_req and rom_addr until rom_ack. On ack, push {rom_data, rom_addr} and set fetch_ptr=rom_addr+1 (wrapping).
  - Back-to-back: if space remains after the push, stay in REQ with the new address next cycle. Otherwise go to IDLE.
  - Maximum throughput is therefore one instruction per cycle with a 1-cycle ROM.
- Pop: an instr_valid && instr_ready handshake pops the FIFO head. instr and instr_pc come from registered FIFO head storage.
- Redirect, with no request outstanding: flush the FIFO, set fetch_ptr=redirect_addr, and issue a request for redirect_addr on the next cycle.
- Redirect in REQ without ack: flush, latch the target, go to DRAIN. rom_req stays high with the old address until ack. The acked data is discarded, then the block requests the target next cycle.
- Redirect in the same cycle as rom_ack: the acked data is discarded, the FIFO is flushed, and the target is requested next cycle (REQ).
- Redirect in DRAIN: the latched target is replaced by the newest redirect_addr.
- Redirect in the same cycle as a pop: the pop counts as consumed, because the CPU is executing the jump it just took. All remaining entries are flushed, and instr_valid=0 in the following cycle.
- Full FIFO with no pop: no new request is issued. A held instr_valid with instr_ready=0 must keep instr and instr_pc stable.
- Fetch pointer wrap: after 2^ADDR_W-1 the pointer goes to 0. No error flag is raised.
- Data path: no combinational path from rom_data to instr, except under the optional feature.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the FIFO is empty, rom_ack=1 and no redirect is present, drive instr=rom_data, instr_pc=rom_addr and instr_valid=1 combinationally in the ack cycle.
  - If instr_ready=1 in that cycle, the word is not pushed.
  - If instr_ready=0, the word is pushed as normal.
  - Result: zero-cycle ack-to-valid latency.
- Undefined: every word passes through the FIFO, and instr_valid first rises the cycle after the ack.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding constants FETCH_IDLE, FETCH_REQ, FETCH_DRAIN;
  - default ADDR_W/DATA_W constants shared with the PC and ROM.
- One natural sub-module: fetch_fifo, a synchronous FIFO holding {data, addr} entries with push, pop, flush and count.
  - Flush has priority over push.
  - Pop on the flush cycle is legal.

Test Plan:
- Release reset with a 1-cycle ROM (ROM[a]=a^16'hA5A5) and instr_ready=1. Expect rom_req at cycle 1 with addr 0, instr_valid at cycle 2, instr_pc 0,1,2,... on consecutive cycles, and instr correct for each.
- 3-cycle ROM with instr_ready=0 held. Expect exactly DEPTH=2 requests (addr 0,1), then rom_req=0. instr stays at 0xA5A5 until ready rises.
- Redirect to 0x0100 on a cycle with a pending request at addr 5 and no ack. Expect state DRAIN, rom_addr held at 5 until ack, addr-5 data never presented, the next request at 0x0100, and the first delivered instr_pc=0x0100.
- Redirect to 0x0040 in the same cycle as rom_ack. Expect the acked word dropped, the FIFO flushed, and rom_addr=0x0040 on the next cycle.
- Redirect to 0x7FFE, then stream 4 words. Expect instr_pc sequence 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- Assert reset mid-stream with the FIFO full and a request pending, then drop the ack. Expect all outputs at their reset values the cycle after reset, with restart from addr 0. With FETCH_BYPASS_EN, expect instr_valid in the ack cycle from empty.
